// File: rtl/vga_pkg.sv
// Shared VGA timing constants (800x600 @ 60 Hz, 40 MHz pixel clock)
// and the state type of the sync decoder.
package vga_pkg;

   localparam int HOR_TOTAL_TIME  = 1056;
   localparam int HOR_BLANK_START = 800;
   localparam int HOR_SYNC_START  = 840;
   localparam int HOR_SYNC_TIME   = 128;

   localparam int VER_TOTAL_TIME  = 628;
   localparam int VER_BLANK_START = 600;
   localparam int VER_SYNC_START  = 601;
   localparam int VER_SYNC_TIME   = 4;

   // Width of the pixel and line counters.
   localparam int CNT_W = 11;

   typedef enum logic [1:0] {
      SEARCH_H,
      SEARCH_V,
      VERIFY,
      LOCKED
   } vga_dec_state_t;

endpackage

// File: rtl/vga_expect.sv
// Expected sync/blank levels for a given (hcount, vcount) position.
// Purely combinational so pattern checkers can reuse it.
module vga_expect
   import vga_pkg::*;
#(
   parameter int H_BLANK_START = HOR_BLANK_START,
   parameter int H_SYNC_START  = HOR_SYNC_START,
   parameter int H_SYNC_TIME   = HOR_SYNC_TIME,
   parameter int V_BLANK_START = VER_BLANK_START,
   parameter int V_SYNC_START  = VER_SYNC_START,
   parameter int V_SYNC_TIME   = VER_SYNC_TIME
) (
   input  logic [CNT_W-1:0] hcount_i,
   input  logic [CNT_W-1:0] vcount_i,
   output logic             hs_e_o,
   output logic             vs_e_o,
   output logic             hb_e_o,
   output logic             vb_e_o
);

   localparam logic [CNT_W-1:0] HS_LO = CNT_W'(H_SYNC_START);
   localparam logic [CNT_W-1:0] HS_HI = CNT_W'(H_SYNC_START + H_SYNC_TIME);
   localparam logic [CNT_W-1:0] VS_LO = CNT_W'(V_SYNC_START);
   localparam logic [CNT_W-1:0] VS_HI = CNT_W'(V_SYNC_START + V_SYNC_TIME);
   localparam logic [CNT_W-1:0] HB_LO = CNT_W'(H_BLANK_START);
   localparam logic [CNT_W-1:0] VB_LO = CNT_W'(V_BLANK_START);

   // Sync pulses are half-open windows; blanking runs to the end of the line/frame.
   assign hs_e_o = (hcount_i >= HS_LO) && (hcount_i < HS_HI);
   assign vs_e_o = (vcount_i >= VS_LO) && (vcount_i < VS_HI);
   assign hb_e_o = (hcount_i >= HB_LO);
   assign vb_e_o = (vcount_i >= VB_LO);

endmodule

// File: rtl/vga_sync_decoder.sv
// Rebuilds hcount/vcount from the sync and blank strobes of a VGA timing
// source. Aligns on the hsync and vsync rising edges, checks every sample
// against the expected timing, and reports lock and per-cycle errors.
// Timing defaults to the package 800x600 values; the overrides exist so a
// scaled-down raster can be used where a full frame is too long.
module vga_sync_decoder
   import vga_pkg::*;
#(
   parameter int LOCK_FRAMES   = 2,
   parameter int LOSS_LINES    = 4,
   parameter int H_TOTAL       = HOR_TOTAL_TIME,
   parameter int H_BLANK_START = HOR_BLANK_START,
   parameter int H_SYNC_START  = HOR_SYNC_START,
   parameter int H_SYNC_TIME   = HOR_SYNC_TIME,
   parameter int V_TOTAL       = VER_TOTAL_TIME,
   parameter int V_BLANK_START = VER_BLANK_START,
   parameter int V_SYNC_START  = VER_SYNC_START,
   parameter int V_SYNC_TIME   = VER_SYNC_TIME
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic             hblnk_in,
   input  logic             vblnk_in,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hsync,
   output logic             vsync,
   output logic             hblnk,
   output logic             vblnk,
   output logic             locked,
   output logic             frame_start,
   output logic             sync_err
);

   localparam int LF_W = $clog2(LOCK_FRAMES + 1);
   localparam int LL_W = $clog2(LOSS_LINES + 1);

   localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_LOAD   = CNT_W'(H_SYNC_START);
   localparam logic [CNT_W-1:0] V_LOAD   = CNT_W'(V_SYNC_START);
   localparam logic [LF_W-1:0]  LOCK_CNT = LF_W'(LOCK_FRAMES);
   localparam logic [LL_W-1:0]  LOSS_CNT = LL_W'(LOSS_LINES);

   vga_dec_state_t   state_q, state_d;
   logic [CNT_W-1:0] hcount_q, hcount_d;
   logic [CNT_W-1:0] vcount_q, vcount_d;
   logic [LF_W-1:0]  clean_frames_q, clean_frames_d;
   logic [LL_W-1:0]  bad_lines_q, bad_lines_d;
   logic             line_bad_q, line_bad_d;
   logic             sync_err_q, sync_err_d;
   logic             locked_q;
   logic             hsync_q, vsync_q, hblnk_q, vblnk_q;

   logic [CNT_W-1:0] h_next, v_next;
   logic             h_wrap, v_wrap;
   logic             hs_e, vs_e, hb_e, vb_e;
   logic             rise_h, rise_v, mismatch;
   logic [LF_W-1:0]  clean_inc;
   logic [LL_W-1:0]  bad_inc;

   // Free-running position step: h wraps each line, v advances on the h wrap.
   always_comb begin
      h_wrap = (hcount_q == H_MAX);
      v_wrap = (vcount_q == V_MAX);
      h_next = h_wrap ? '0 : hcount_q + CNT_W'(1);
      v_next = vcount_q;
      if (h_wrap) begin
         v_next = v_wrap ? '0 : vcount_q + CNT_W'(1);
      end
   end

   vga_expect #(
      .H_BLANK_START (H_BLANK_START),
      .H_SYNC_START  (H_SYNC_START),
      .H_SYNC_TIME   (H_SYNC_TIME),
      .V_BLANK_START (V_BLANK_START),
      .V_SYNC_START  (V_SYNC_START),
      .V_SYNC_TIME   (V_SYNC_TIME)
   ) u_expect (
      .hcount_i (h_next),
      .vcount_i (v_next),
      .hs_e_o   (hs_e),
      .vs_e_o   (vs_e),
      .hb_e_o   (hb_e),
      .vb_e_o   (vb_e)
   );

   // The incoming sample sits at (h_next, v_next); edges use the delayed copies.
   assign rise_h    = hsync_in & ~hsync_q;
   assign rise_v    = vsync_in & ~vsync_q;
   assign mismatch  = (hsync_in != hs_e) | (vsync_in != vs_e) |
                      (hblnk_in != hb_e) | (vblnk_in != vb_e);
   assign clean_inc = clean_frames_q + LF_W'(1);
   assign bad_inc   = bad_lines_q + LL_W'(1);

   // Next-state logic: alignment search, frame verification and lock supervision.
   always_comb begin
      // NOTE: every signal written here is given a default first, so no path
      // leaves a value unassigned and no latch can be inferred.
      state_d        = state_q;
      hcount_d       = h_next;
      vcount_d       = v_next;
      clean_frames_d = clean_frames_q;
      bad_lines_d    = bad_lines_q;
      line_bad_d     = line_bad_q;
      sync_err_d     = 1'b0;

      case (state_q)
         SEARCH_H: begin
            clean_frames_d = '0;
            bad_lines_d    = '0;
            line_bad_d     = 1'b0;
            if (rise_h) begin
               hcount_d = H_LOAD;
               state_d  = SEARCH_V;
            end
         end

         SEARCH_V: begin
            if (rise_v) begin
               if (h_next == '0) begin
                  vcount_d = V_LOAD;
                  state_d  = VERIFY;
               end else begin
                  state_d = SEARCH_H;
               end
            end
         end

         VERIFY: begin
            if (mismatch) begin
               sync_err_d     = 1'b1;
               clean_frames_d = '0;
               state_d        = SEARCH_H;
            end else if (h_wrap && v_wrap) begin
               if (clean_inc == LOCK_CNT) begin
                  clean_frames_d = '0;
                  state_d        = LOCKED;
               end else begin
                  clean_frames_d = clean_inc;
               end
            end
         end

         LOCKED: begin
            sync_err_d = mismatch;
            if (h_wrap) begin
               // The wrap-cycle sample is the first pixel of the new line.
               line_bad_d = mismatch;
               if (line_bad_q) begin
                  if (bad_inc == LOSS_CNT) begin
                     bad_lines_d = '0;
                     state_d     = SEARCH_H;
                  end else begin
                     bad_lines_d = bad_inc;
                  end
               end else begin
                  bad_lines_d = '0;
               end
            end else begin
               line_bad_d = line_bad_q | mismatch;
            end
         end

         default: state_d = SEARCH_H;
      endcase
   end

   // Registers: delayed inputs, counters, FSM state and status flags.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q        <= SEARCH_H;
         hcount_q       <= '0;
         vcount_q       <= '0;
         clean_frames_q <= '0;
         bad_lines_q    <= '0;
         line_bad_q     <= 1'b0;
         sync_err_q     <= 1'b0;
         locked_q       <= 1'b0;
         hsync_q        <= 1'b0;
         vsync_q        <= 1'b0;
         hblnk_q        <= 1'b0;
         vblnk_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         hcount_q       <= hcount_d;
         vcount_q       <= vcount_d;
         clean_frames_q <= clean_frames_d;
         bad_lines_q    <= bad_lines_d;
         line_bad_q     <= line_bad_d;
         sync_err_q     <= sync_err_d;
         locked_q       <= (state_d == LOCKED);
         hsync_q        <= hsync_in;
         vsync_q        <= vsync_in;
         hblnk_q        <= hblnk_in;
         vblnk_q        <= vblnk_in;
      end
   end

   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign hblnk       = hblnk_q;
   assign vblnk       = vblnk_q;
   assign locked      = locked_q;
   assign sync_err    = sync_err_q;
   assign frame_start = locked_q && (hcount_q == '0) && (vcount_q == '0);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down raster. A bench-side timing
// source produces the strobes from its own position counters; expected
// outputs come from that position and the sync/blank window rules.
module tb_vga_sync_decoder;

   localparam int HT  = 40;   // pixels per line
   localparam int HBS = 30;   // horizontal blank start
   localparam int HSS = 32;   // hsync start
   localparam int HST = 4;    // hsync width
   localparam int VT  = 20;   // lines per frame
   localparam int VBS = 15;   // vertical blank start
   localparam int VSS = 16;   // vsync start line
   localparam int VST = 2;    // vsync height in lines
   localparam int FRAME = HT * VT;
   localparam int LOCK_FRAMES = 2;
   localparam int LOSS_LINES  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
   logic [10:0] hcount, vcount;
   logic        hsync, vsync, hblnk, vblnk, locked, frame_start, sync_err;

   int errors = 0;
   int checks = 0;

   // Source position of the next sample to drive.
   int src_h, src_v;
   // The sample captured at the most recent edge.
   int ap_h, ap_v;
   logic [3:0] ap_in;
   logic ap_rst;
   // Stimulus modifiers.
   bit hs_kill  = 1'b0;
   bit vs_shift = 1'b0;
   // 0: only delayed strobes checked, 1: locked and aligned, 2: known unlocked.
   int mode = 0;
   int cyc = 0;
   int err_pulses = 0;

   vga_sync_decoder #(
      .LOCK_FRAMES   (LOCK_FRAMES),
      .LOSS_LINES    (LOSS_LINES),
      .H_TOTAL       (HT),
      .H_BLANK_START (HBS),
      .H_SYNC_START  (HSS),
      .H_SYNC_TIME   (HST),
      .V_TOTAL       (VT),
      .V_BLANK_START (VBS),
      .V_SYNC_START  (VSS),
      .V_SYNC_TIME   (VST)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .hblnk_in    (hblnk_in),
      .vblnk_in    (vblnk_in),
      .hcount      (hcount),
      .vcount      (vcount),
      .hsync       (hsync),
      .vsync       (vsync),
      .hblnk       (hblnk),
      .vblnk       (vblnk),
      .locked      (locked),
      .frame_start (frame_start),
      .sync_err    (sync_err)
   );

   always #5 clk = ~clk;

   // {hsync, vsync, hblnk, vblnk} a clean source shows at position (h, v).
   function automatic logic [3:0] levels(input int h, input int v);
      levels = {(h >= HSS) && (h < HSS + HST),
                (v >= VSS) && (v < VSS + VST),
                (h >= HBS),
                (v >= VBS)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: drive the source sample, capture it at the edge, advance the
   // source, then compare the DUT outputs 1 time unit later.
   task automatic tick();
      logic [3:0] lv;
      int pos;
      lv  = levels(src_h, src_v);
      pos = src_v * HT + src_h;
      hsync_in = lv[3] & ~hs_kill;
      vsync_in = vs_shift ? ((pos >= VSS * HT + 10) && (pos < (VSS + VST) * HT + 10)) : lv[2];
      hblnk_in = lv[1];
      vblnk_in = lv[0];
      @(posedge clk);
      ap_h   = src_h;
      ap_v   = src_v;
      ap_rst = rst;
      ap_in  = {hsync_in, vsync_in, hblnk_in, vblnk_in};
      if (src_h == HT - 1) begin
         src_h = 0;
         src_v = (src_v == VT - 1) ? 0 : src_v + 1;
      end else begin
         src_h++;
      end
      #1;
      cyc++;
      if (sync_err === 1'b1) err_pulses++;
      if (ap_rst) begin
         check("rst_outputs",
               {hcount, vcount, hsync, vsync, hblnk, vblnk, locked, frame_start, sync_err}, 0);
      end else begin
         check("delayed_strobes", {hsync, vsync, hblnk, vblnk}, ap_in);
         if (mode == 1) begin
            check("hcount", hcount, ap_h);
            check("vcount", vcount, ap_v);
            check("locked_hi", locked, 1);
            check("frame_start", frame_start, (ap_h == 0) && (ap_v == 0));
            check("sync_err", sync_err, ap_in != levels(ap_h, ap_v));
         end else if (mode == 2) begin
            check("unlocked_flags", {locked, frame_start, sync_err}, 0);
         end
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) tick();
      rst = 1'b0;
   endtask

   // Wait (bounded) for locked; lock can only come on a frame wrap sample.
   task automatic wait_lock(input string tag);
      int n;
      n = 0;
      mode = 0;
      while (locked !== 1'b1 && n < 3 * FRAME) begin
         tick();
         n++;
      end
      check({tag, "_in_time"}, locked, 1);
      check({tag, "_at_origin"}, {hcount, vcount}, 0);
      check({tag, "_aligned"}, {hcount, vcount}, {ap_h[10:0], ap_v[10:0]});
      check({tag, "_frame_start"}, frame_start, 1);
   endtask

   initial begin
      int fs_count, fs_prev, fs_gap, g, gv, line_l, tgt, n;

      // Power-up reset with the source mid-line, outside the hsync pulse.
      src_h = $urandom_range(HSS - 3, 0);
      src_v = $urandom_range(VT - 1, 0);
      do_reset(3);
      wait_lock("lock1");

      // Steady lock: two frames of full comparisons, frame marker spacing.
      mode = 1;
      fs_count = 0;
      fs_prev  = 0;
      fs_gap   = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         if (frame_start === 1'b1) begin
            fs_count++;
            if (fs_count > 1) fs_gap = cyc - fs_prev;
            fs_prev = cyc;
         end
      end
      check("frame_start_count", fs_count, 2);
      check("frame_start_gap", fs_gap, FRAME);

      // Single-cycle hsync glitch while locked.
      g  = $urandom_range(HSS + HST - 2, HSS + 1);
      gv = $urandom_range(VT - 1, 0);
      n  = 0;
      while (!(src_h == g && src_v == gv) && n < 2 * FRAME) begin
         tick();
         n++;
      end
      err_pulses = 0;
      hs_kill = 1'b1;
      tick();
      hs_kill = 1'b0;
      for (int i = 0; i < 2 * HT; i++) tick();
      check("glitch_err_pulses", err_pulses, 1);
      check("glitch_locked", locked, 1);

      // Loss: hsync held low for five lines from a line start.
      line_l = $urandom_range(VT - 1, 0);
      n = 0;
      while (!(src_h == 0 && src_v == line_l) && n < 2 * FRAME) begin
         tick();
         n++;
      end
      err_pulses = 0;
      hs_kill = 1'b1;
      for (int k = 0; k < 5 * HT; k++) begin
         mode = (k < LOSS_LINES * HT) ? 1 : 2;
         tick();
      end
      hs_kill = 1'b0;
      check("loss_err_pulses", err_pulses, LOSS_LINES * HST);
      check("loss_locked", locked, 0);
      wait_lock("lock2");

      // Reset for two clocks while locked, then relock.
      mode = 1;
      tgt = $urandom_range(HSS - 3, 0);
      n = 0;
      while (src_h != tgt && n < 2 * HT) begin
         tick();
         n++;
      end
      do_reset(2);
      wait_lock("lock3");

      // vsync rise displaced to h=10: alignment must never complete.
      mode = 1;
      tgt = $urandom_range(HSS - 3, 0);
      n = 0;
      while (src_h != tgt && n < 2 * HT) begin
         tick();
         n++;
      end
      mode = 2;
      vs_shift = 1'b1;
      do_reset(2);
      for (int i = 0; i < 3 * FRAME; i++) tick();
      n = 0;
      while (!(src_h == 0 && src_v == 0) && n < 2 * FRAME) begin
         tick();
         n++;
      end
      check("misaligned_locked", locked, 0);
      vs_shift = 1'b0;
      wait_lock("lock4");

      // One more clean frame after recovery.
      mode = 1;
      for (int i = 0; i < FRAME; i++) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
